// File: rtl/id_ex_decode.sv
// ID/EX pipeline stage for an RV32I core.
// This stage decodes the instruction presented in ID into ALU operands, an ALU
// op code and control flags. The result is held in a one-entry
// valid/ready register that feeds EX.
// ALU op codes mirror the alu.vh table used by the EX stage.
module id_ex_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_c,
  output logic [31:0] imm,
  output logic [4:0]  rd,
  output logic        rd_we,
  output logic        br,
  output logic        jump,
  output logic        load,
  output logic        store,
  output logic [1:0]  shift_op,
  output logic        illegal
);

  localparam logic [4:0] IADD                 = 5'd0;
  localparam logic [4:0] SUB                  = 5'd1;
  localparam logic [4:0] IXOR                 = 5'd2;
  localparam logic [4:0] IOR                  = 5'd3;
  localparam logic [4:0] IAND                 = 5'd4;
  localparam logic [4:0] lessThan             = 5'd5;
  localparam logic [4:0] lessThanUnsigned     = 5'd6;
  localparam logic [4:0] equal                = 5'd7;
  localparam logic [4:0] notEqual             = 5'd8;
  localparam logic [4:0] greaterEqual         = 5'd9;
  localparam logic [4:0] greaterEqualUnsigned = 5'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_SLL  = 2'b01;
  localparam logic [1:0] SH_SRL  = 2'b10;
  localparam logic [1:0] SH_SRA  = 2'b11;

  typedef struct packed {
    logic [31:0] aluA;
    logic [31:0] aluB;
    logic [4:0]  aluC;
    logic [31:0] imm;
    logic        rdWe;
    logic        br;
    logic        jump;
    logic        load;
    logic        store;
    logic [1:0]  shiftOp;
    logic        illegal;
  } decT;

  // Immediate extraction; every format sign-extends from instr[31].
  function automatic logic signed [31:0] immI(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic signed [31:0] immS(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic signed [31:0] immB(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic signed [31:0] immU(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  function automatic logic signed [31:0] immJ(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  // Full decode of one instruction into the fields registered for EX.
  function automatic decT decode(input logic [31:0] ins, input logic [31:0] pcV,
                                 input logic [31:0] rs1V, input logic [31:0] rs2V);
    decT d;
    logic [2:0] f3;
    logic [6:0] f7;
    d = '0;
    d.aluC = IADD;
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (ins[6:0])
      OPC_OP: begin
        d.aluA = rs1V;
        d.aluB = rs2V;
        d.rdWe = 1'b1;
        case (f3)
          3'b000: if (f7 == F7_ZERO) d.aluC = IADD;
                  else if (f7 == F7_ALT) d.aluC = SUB;
                  else d.illegal = 1'b1;
          3'b001: if (f7 == F7_ZERO) d.shiftOp = SH_SLL; else d.illegal = 1'b1;
          3'b101: if (f7 == F7_ZERO) d.shiftOp = SH_SRL;
                  else if (f7 == F7_ALT) d.shiftOp = SH_SRA;
                  else d.illegal = 1'b1;
          3'b010: if (f7 == F7_ZERO) d.aluC = lessThan; else d.illegal = 1'b1;
          3'b011: if (f7 == F7_ZERO) d.aluC = lessThanUnsigned; else d.illegal = 1'b1;
          3'b100: if (f7 == F7_ZERO) d.aluC = IXOR; else d.illegal = 1'b1;
          3'b110: if (f7 == F7_ZERO) d.aluC = IOR; else d.illegal = 1'b1;
          default: if (f7 == F7_ZERO) d.aluC = IAND; else d.illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        d.aluA = rs1V;
        d.aluB = immI(ins);
        d.imm  = immI(ins);
        d.rdWe = 1'b1;
        case (f3)
          3'b000: d.aluC = IADD;
          3'b010: d.aluC = lessThan;
          3'b011: d.aluC = lessThanUnsigned;
          3'b100: d.aluC = IXOR;
          3'b110: d.aluC = IOR;
          3'b111: d.aluC = IAND;
          3'b001: begin
            d.aluB = {27'b0, ins[24:20]};
            if (f7 == F7_ZERO) d.shiftOp = SH_SLL; else d.illegal = 1'b1;
          end
          default: begin
            d.aluB = {27'b0, ins[24:20]};
            if (f7 == F7_ZERO) d.shiftOp = SH_SRL;
            else if (f7 == F7_ALT) d.shiftOp = SH_SRA;
            else d.illegal = 1'b1;
          end
        endcase
      end
      OPC_BRANCH: begin
        d.aluA = rs1V;
        d.aluB = rs2V;
        d.imm  = immB(ins);
        d.br   = 1'b1;
        case (f3)
          3'b000:  d.aluC = equal;
          3'b001:  d.aluC = notEqual;
          3'b100:  d.aluC = lessThan;
          3'b101:  d.aluC = greaterEqual;
          3'b110:  d.aluC = lessThanUnsigned;
          3'b111:  d.aluC = greaterEqualUnsigned;
          default: d.illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        d.aluB = immU(ins);
        d.imm  = immU(ins);
        d.rdWe = 1'b1;
      end
      OPC_AUIPC: begin
        d.aluA = pcV;
        d.aluB = immU(ins);
        d.imm  = immU(ins);
        d.rdWe = 1'b1;
      end
      OPC_JAL: begin
        d.aluA = pcV;
        d.aluB = 32'd4;
        d.imm  = immJ(ins);
        d.jump = 1'b1;
        d.rdWe = 1'b1;
      end
      OPC_JALR: begin
        d.aluA = pcV;
        d.aluB = 32'd4;
        d.imm  = immI(ins);
        d.jump = 1'b1;
        d.rdWe = 1'b1;
        if (f3 != 3'b000) d.illegal = 1'b1;
      end
      OPC_LOAD: begin
        d.aluA = rs1V;
        d.aluB = immI(ins);
        d.imm  = immI(ins);
        d.load = 1'b1;
        d.rdWe = 1'b1;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) d.illegal = 1'b1;
      end
      OPC_STORE: begin
        d.aluA  = rs1V;
        d.aluB  = immS(ins);
        d.imm   = immS(ins);
        d.store = 1'b1;
        if (f3 > 3'b010) d.illegal = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    // An illegal encoding carries no side effects into EX.
    if (d.illegal) begin
      d = '0;
      d.aluC = IADD;
      d.illegal = 1'b1;
    end
    // x0 is never written.
    if (ins[11:7] == 5'd0) d.rdWe = 1'b0;
    return d;
  endfunction

  decT decP0;
  logic capture;

  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // Decode stage input (same cycle as instr)
  always_comb begin
    decP0 = decode(instr, pc, rs1_data, rs2_data);
  end

  // Valid flag: flush wins, then a new capture, then EX draining the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // ID/EX boundary: decoded fields load on capture and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_c    <= '0;
      imm      <= '0;
      rd       <= '0;
      rd_we    <= 1'b0;
      br       <= 1'b0;
      jump     <= 1'b0;
      load     <= 1'b0;
      store    <= 1'b0;
      shift_op <= '0;
      illegal  <= 1'b0;
    end else if (capture) begin
      alu_a    <= decP0.aluA;
      alu_b    <= decP0.aluB;
      alu_c    <= decP0.aluC;
      imm      <= decP0.imm;
      rd       <= instr[11:7];
      rd_we    <= decP0.rdWe;
      br       <= decP0.br;
      jump     <= decP0.jump;
      load     <= decP0.load;
      store    <= decP0.store;
      shift_op <= decP0.shiftOp;
      illegal  <= decP0.illegal;
    end
  end

endmodule

// File: tb/tb_id_ex_decode.sv
// Directed bench for the ID/EX decode register.
module tb_id_ex_decode;

  localparam logic [4:0] IADD     = 5'd0;
  localparam logic [4:0] SUB      = 5'd1;
  localparam logic [4:0] lessThan = 5'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_c;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic        rd_we;
  logic        br;
  logic        jump;
  logic        load;
  logic        store;
  logic [1:0]  shift_op;
  logic        illegal;

  int nCmp = 0;
  int nErr = 0;

  id_ex_decode dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_c(alu_c), .imm(imm), .rd(rd), .rd_we(rd_we), .br(br), .jump(jump),
    .load(load), .store(store), .shift_op(shift_op), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] pcV,
                         input logic [31:0] a, input logic [31:0] b);
    instr = ins; pc = pcV; rs1_data = a; rs2_data = b;
  endtask

  // One transfer with EX always ready; leaves in_valid low afterwards.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pcV,
                       input logic [31:0] a, input logic [31:0] b);
    present(ins, pcV, a, b);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    nCmp++; if (out_valid !== 1'b0) begin nErr++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    nCmp++; if ({alu_a, alu_b, alu_c, imm, rd} !== '0) begin nErr++; $display("FAIL reset_data got %h/%h/%0d/%h/%0d want zeros", alu_a, alu_b, alu_c, imm, rd); end
    nCmp++; if ({rd_we, br, jump, load, store, shift_op, illegal} !== 8'd0) begin nErr++; $display("FAIL reset_flags got %b want 0", {rd_we, br, jump, load, store, shift_op, illegal}); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    nCmp++; if (in_ready !== 1'b1) begin nErr++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_add();
    present(32'h00208133, 32'h100, 32'd5, 32'd7);
    #1;
    nCmp++; if ({rs1_addr, rs2_addr} !== {5'd1, 5'd2}) begin nErr++; $display("FAIL rf_addr got %0d,%0d want 1,2", rs1_addr, rs2_addr); end
    issue(32'h00208133, 32'h100, 32'd5, 32'd7);
    nCmp++; if (out_valid !== 1'b1) begin nErr++; $display("FAIL add_valid got %0b want 1", out_valid); end
    nCmp++; if (alu_a !== 32'd5 || alu_b !== 32'd7) begin nErr++; $display("FAIL add_ops got %h,%h want 5,7", alu_a, alu_b); end
    nCmp++; if (alu_c !== IADD || rd !== 5'd2 || rd_we !== 1'b1 || shift_op !== 2'b00 || illegal !== 1'b0) begin nErr++; $display("FAIL add_ctl got c=%0d rd=%0d we=%0b sh=%0d il=%0b want 0,2,1,0,0", alu_c, rd, rd_we, shift_op, illegal); end
    issue(32'h402081B3, 32'h104, 32'd9, 32'd4);
    nCmp++; if (alu_c !== SUB || rd !== 5'd3 || rd_we !== 1'b1) begin nErr++; $display("FAIL sub got c=%0d rd=%0d we=%0b want 1,3,1", alu_c, rd, rd_we); end
    issue(32'h00208033, 32'h108, 32'd9, 32'd4);
    nCmp++; if (rd !== 5'd0 || rd_we !== 1'b0) begin nErr++; $display("FAIL rd0 got rd=%0d we=%0b want 0,0", rd, rd_we); end
  endtask

  task automatic test_opimm();
    issue(32'hFFF00093, 32'h10C, 32'h11, 32'h22);
    nCmp++; if (alu_a !== 32'h11 || alu_b !== 32'hFFFFFFFF || imm !== 32'hFFFFFFFF) begin nErr++; $display("FAIL addi_ops got %h,%h,%h want 11,ffffffff,ffffffff", alu_a, alu_b, imm); end
    nCmp++; if (alu_c !== IADD || rd !== 5'd1 || rd_we !== 1'b1 || illegal !== 1'b0) begin nErr++; $display("FAIL addi_ctl got c=%0d rd=%0d we=%0b il=%0b want 0,1,1,0", alu_c, rd, rd_we, illegal); end
    // srai x3,x1,4
    issue(32'h4040D193, 32'h110, 32'h80000000, 32'h5);
    nCmp++; if (alu_a !== 32'h80000000 || alu_b !== 32'd4 || shift_op !== 2'b11 || alu_c !== IADD || rd !== 5'd3) begin nErr++; $display("FAIL srai got %h,%h sh=%0d c=%0d rd=%0d want 80000000,4,3,0,3", alu_a, alu_b, shift_op, alu_c, rd); end
    // slli with funct7=0000001 is not a legal encoding
    issue(32'h02009093, 32'h114, 32'h33, 32'h44);
    nCmp++; if (illegal !== 1'b1 || rd_we !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0 || shift_op !== 2'b00) begin nErr++; $display("FAIL slli_bad got il=%0b we=%0b a=%h b=%h sh=%0d want 1,0,0,0,0", illegal, rd_we, alu_a, alu_b, shift_op); end
  endtask

  task automatic test_branch_jump();
    // blt x1,x2,+8
    issue(32'h0020C463, 32'h200, 32'd3, 32'd9);
    nCmp++; if (br !== 1'b1 || alu_c !== lessThan || imm !== 32'd8 || rd_we !== 1'b0) begin nErr++; $display("FAIL blt got br=%0b c=%0d imm=%h we=%0b want 1,5,8,0", br, alu_c, imm, rd_we); end
    nCmp++; if (alu_a !== 32'd3 || alu_b !== 32'd9) begin nErr++; $display("FAIL blt_ops got %h,%h want 3,9", alu_a, alu_b); end
    // funct3=010 is not a branch condition
    issue(32'h00C0A463, 32'h204, 32'd3, 32'd9);
    nCmp++; if (illegal !== 1'b1 || br !== 1'b0 || alu_a !== 32'd0) begin nErr++; $display("FAIL br_f3_bad got il=%0b br=%0b a=%h want 1,0,0", illegal, br, alu_a); end
    issue(32'h123452B7, 32'h300, 32'hAAAA, 32'hBBBB);
    nCmp++; if (alu_a !== 32'd0 || alu_b !== 32'h12345000 || rd !== 5'd5 || rd_we !== 1'b1) begin nErr++; $display("FAIL lui got %h,%h rd=%0d we=%0b want 0,12345000,5,1", alu_a, alu_b, rd, rd_we); end
    // jal x1,+16
    issue(32'h010000EF, 32'h400, 32'h1, 32'h2);
    nCmp++; if (alu_a !== 32'h400 || alu_b !== 32'd4 || jump !== 1'b1 || imm !== 32'd16 || rd !== 5'd1 || rd_we !== 1'b1) begin nErr++; $display("FAIL jal got %h,%h j=%0b imm=%h rd=%0d want 400,4,1,10,1", alu_a, alu_b, jump, imm, rd); end
    issue(32'h0000007F, 32'h404, 32'h1, 32'h2);
    nCmp++; if (illegal !== 1'b1 || rd_we !== 1'b0 || jump !== 1'b0 || alu_c !== IADD) begin nErr++; $display("FAIL undef got il=%0b we=%0b j=%0b c=%0d want 1,0,0,0", illegal, rd_we, jump, alu_c); end
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    tick();
    present(32'h00208133, 32'h500, 32'd5, 32'd7);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    nCmp++; if (out_valid !== 1'b1) begin nErr++; $display("FAIL stall_load got %0b want 1", out_valid); end
    present(32'h123452B7, 32'h504, 32'd1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      nCmp++; if (in_ready !== 1'b0) begin nErr++; $display("FAIL stall_in_ready[%0d] got %0b want 0", i, in_ready); end
      tick();
      nCmp++; if (out_valid !== 1'b1 || alu_a !== 32'd5 || alu_b !== 32'd7 || rd !== 5'd2) begin nErr++; $display("FAIL stall_hold[%0d] got v=%0b %h,%h rd=%0d want 1,5,7,2", i, out_valid, alu_a, alu_b, rd); end
    end
    out_ready = 1'b1;
    #1;
    nCmp++; if (in_ready !== 1'b1) begin nErr++; $display("FAIL release_in_ready got %0b want 1", in_ready); end
    tick();
    nCmp++; if (out_valid !== 1'b1 || alu_b !== 32'h12345000 || rd !== 5'd5) begin nErr++; $display("FAIL back_to_back got v=%0b b=%h rd=%0d want 1,12345000,5", out_valid, alu_b, rd); end
    in_valid = 1'b0;
    tick();
    nCmp++; if (out_valid !== 1'b0) begin nErr++; $display("FAIL drain got %0b want 0", out_valid); end
  endtask

  task automatic test_flush();
    present(32'h00208133, 32'h600, 32'd5, 32'd7);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    present(32'h123452B7, 32'h604, 32'd1, 32'd2);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    nCmp++; if (out_valid !== 1'b0) begin nErr++; $display("FAIL flush_valid got %0b want 0", out_valid); end
    nCmp++; if (alu_b !== 32'd7 || rd !== 5'd2) begin nErr++; $display("FAIL flush_nocapture got b=%h rd=%0d want 7,2", alu_b, rd); end
  endtask

  task automatic test_reset_mid_stall();
    present(32'h00208133, 32'h700, 32'd5, 32'd7);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    nCmp++; if (out_valid !== 1'b0 || alu_a !== 32'd0 || rd !== 5'd0 || rd_we !== 1'b0) begin nErr++; $display("FAIL reset_mid_stall got v=%0b a=%h rd=%0d we=%0b want 0,0,0,0", out_valid, alu_a, rd, rd_we); end
    tick();
    rst_n = 1'b1;
    tick();
    nCmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin nErr++; $display("FAIL post_reset got rdy=%0b v=%0b want 1,0", in_ready, out_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_opimm();
    test_branch_jump();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
